// File: rtl/dco_word_seq.sv
// dco_word_seq: slew-limited ramp sequencer feeding the DCO row/column coder word input.
// Optional macro DCO_SEQ_SLEW_EN enables step limiting; otherwise each target is reached in one step.
`default_nettype none

module dco_word_seq #(
    parameter int WORD_W = 8,
    parameter int STEP_W = 3,
    parameter int DIV_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tgt_valid,
    input  logic [WORD_W-1:0] tgt_word,
    output logic              tgt_ready,
    input  logic [STEP_W-1:0] step_max,
    input  logic [DIV_W-1:0]  upd_div,
    output logic [WORD_W-1:0] cod_word,
    output logic              cod_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [WORD_W-1:0] WORD_RST = {1'b1, {(WORD_W-1){1'b0}}};

    state_t              state, state_n;
    logic [WORD_W-1:0]   tgt_q, tgt_q_n;
    logic [DIV_W-1:0]    cnt, cnt_n;
    logic [WORD_W-1:0]   word_n;
    logic                en_n, done_n;
    logic                eq_pend, eq_pend_n;

    logic                up;
    logic [WORD_W-1:0]   mag;
    logic [WORD_W-1:0]   step_sz;
    logic [WORD_W-1:0]   word_step;

    // Equal-target acceptance defers done by one edge; ready is held off meanwhile.
    assign tgt_ready = (state == IDLE) && !eq_pend;
    assign busy      = (state == WAIT);

    always_comb begin
        up  = (tgt_q > cod_word);
        mag = up ? (tgt_q - cod_word) : (cod_word - tgt_q);
`ifdef DCO_SEQ_SLEW_EN
        step_sz = {{(WORD_W-STEP_W){1'b0}}, step_max};
        if (step_max == '0) begin
            step_sz = WORD_W'(1);
        end
        if (mag < step_sz) begin
            step_sz = mag;
        end
`else
        step_sz = mag;
`endif
        word_step = up ? (cod_word + step_sz) : (cod_word - step_sz);
    end

`ifndef DCO_SEQ_SLEW_EN
    logic unused_step_max;
    assign unused_step_max = ^step_max;
`endif

    always_comb begin
        state_n   = state;
        tgt_q_n   = tgt_q;
        cnt_n     = cnt;
        word_n    = cod_word;
        en_n      = 1'b0;
        done_n    = 1'b0;
        eq_pend_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (eq_pend) begin
                    done_n = 1'b1;
                end else if (tgt_valid) begin
                    tgt_q_n = tgt_word;
                    if (tgt_word == cod_word) begin
                        eq_pend_n = 1'b1;
                    end else begin
                        cnt_n   = upd_div;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - DIV_W'(1);
                end else begin
                    word_n = word_step;
                    en_n   = 1'b1;
                    if (word_step == tgt_q) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = upd_div;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tgt_q    <= '0;
            cnt      <= '0;
            cod_word <= WORD_RST;
            cod_en   <= 1'b0;
            done     <= 1'b0;
            eq_pend  <= 1'b0;
        end else begin
            state    <= state_n;
            tgt_q    <= tgt_q_n;
            cnt      <= cnt_n;
            cod_word <= word_n;
            cod_en   <= en_n;
            done     <= done_n;
            eq_pend  <= eq_pend_n;
        end
    end

endmodule

`default_nettype wire
